// File: rtl/seq_branch_comparator_if.sv
// Handshake and operand/result bundle for the sequential branch comparator.
interface seq_branch_comparator_if #(
  parameter int unsigned BUS_WIDTH = 64
) ();
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] in1;
  logic [BUS_WIDTH-1:0] in2;
  logic [2:0]           funct3;
  logic                 out_valid;
  logic                 out_ready;
  logic                 zero;
  logic                 neg;
  logic                 negu;
  logic                 taken;
  logic                 illegal;

  modport master (
    output flush, in_valid, in1, in2, funct3, out_ready,
    input  in_ready, out_valid, zero, neg, negu, taken, illegal
  );

  modport slave (
    input  flush, in_valid, in1, in2, funct3, out_ready,
    output in_ready, out_valid, zero, neg, negu, taken, illegal
  );
endinterface

// File: rtl/seq_branch_comparator.sv
// Multi-cycle branch comparator: compares two operands one slice per cycle,
// most significant slice first, and resolves the RISC-V branch outcome.
module seq_branch_comparator #(
  parameter int unsigned BUS_WIDTH   = 64,
  parameter int unsigned SLICE_WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_branch_comparator_if.slave bus
);
  localparam int unsigned NUM_SLICES = BUS_WIDTH / SLICE_WIDTH;
  localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [BUS_WIDTH-1:0] r_a, w_a_next;
  logic [BUS_WIDTH-1:0] r_b, w_b_next;
  logic [2:0]           r_f3, w_f3_next;
  logic                 r_eq, w_eq_next;
  logic                 r_lts, w_lts_next;
  logic                 r_ltu, w_ltu_next;
  logic                 r_out_valid, w_out_valid_next;
  logic                 r_zero, w_zero_next;
  logic                 r_neg, w_neg_next;
  logic                 r_negu, w_negu_next;
  logic                 r_taken, w_taken_next;
  logic                 r_illegal, w_illegal_next;

  // Operands shift left each BUSY cycle, so the slice under test is always the top one.
  logic [SLICE_WIDTH-1:0] w_a_slice, w_b_slice;
  logic                   w_eq_step, w_lts_step, w_ltu_step;

  assign w_a_slice = r_a[BUS_WIDTH-1 -: SLICE_WIDTH];
  assign w_b_slice = r_b[BUS_WIDTH-1 -: SLICE_WIDTH];

  function automatic logic f_taken(input logic [2:0] f3, input logic z, input logic n,
                                   input logic nu);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = n;
      3'b101:  t = !n;
      3'b110:  t = nu;
      3'b111:  t = !nu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Fold the current slice into the running equal/less-than accumulators.
  always_comb begin
    w_eq_step  = r_eq;
    w_lts_step = r_lts;
    w_ltu_step = r_ltu;
    // Only the first differing slice decides; signed compare matters only for the MSB slice.
    if (r_eq && (w_a_slice != w_b_slice)) begin
      w_eq_step  = 1'b0;
      w_ltu_step = (w_a_slice < w_b_slice);
      w_lts_step = (r_cnt == '0) ? ($signed(w_a_slice) < $signed(w_b_slice))
                                 : (w_a_slice < w_b_slice);
    end
  end

  // Next-state and datapath control; flush overrides every state.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_a_next         = r_a;
    w_b_next         = r_b;
    w_f3_next        = r_f3;
    w_eq_next        = r_eq;
    w_lts_next       = r_lts;
    w_ltu_next       = r_ltu;
    w_out_valid_next = r_out_valid;
    w_zero_next      = r_zero;
    w_neg_next       = r_neg;
    w_negu_next      = r_negu;
    w_taken_next     = r_taken;
    w_illegal_next   = r_illegal;
    if (bus.flush) begin
      w_state_next     = StIdle;
      w_out_valid_next = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            w_a_next     = bus.in1;
            w_b_next     = bus.in2;
            w_f3_next    = bus.funct3;
            w_cnt_next   = '0;
            w_eq_next    = 1'b1;
            w_lts_next   = 1'b0;
            w_ltu_next   = 1'b0;
            w_state_next = StBusy;
          end
        end
        StBusy: begin
          w_eq_next  = w_eq_step;
          w_lts_next = w_lts_step;
          w_ltu_next = w_ltu_step;
          w_a_next   = r_a << SLICE_WIDTH;
          w_b_next   = r_b << SLICE_WIDTH;
          if (r_cnt == LAST_CNT) begin
            w_zero_next      = w_eq_step;
            w_neg_next       = w_lts_step;
            w_negu_next      = w_ltu_step;
            w_taken_next     = f_taken(r_f3, w_eq_step, w_lts_step, w_ltu_step);
            w_illegal_next   = (r_f3[2:1] == 2'b01);
            w_out_valid_next = 1'b1;
            w_state_next     = StDone;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            w_out_valid_next = 1'b0;
            w_state_next     = StIdle;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_f3        <= '0;
      r_eq        <= 1'b0;
      r_lts       <= 1'b0;
      r_ltu       <= 1'b0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_negu      <= 1'b0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_a         <= w_a_next;
      r_b         <= w_b_next;
      r_f3        <= w_f3_next;
      r_eq        <= w_eq_next;
      r_lts       <= w_lts_next;
      r_ltu       <= w_ltu_next;
      r_out_valid <= w_out_valid_next;
      r_zero      <= w_zero_next;
      r_neg       <= w_neg_next;
      r_negu      <= w_negu_next;
      r_taken     <= w_taken_next;
      r_illegal   <= w_illegal_next;
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = r_out_valid;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.negu      = r_negu;
  assign bus.taken     = r_taken;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_seq_branch_comparator.sv
// Randomised self-checking bench for seq_branch_comparator against a full-width model.
module tb_seq_branch_comparator;
  localparam int unsigned BW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_branch_comparator_if #(.BUS_WIDTH(BW)) bus ();
  seq_branch_comparator_if #(.BUS_WIDTH(BW)) bus1 ();

  seq_branch_comparator #(.BUS_WIDTH(BW), .SLICE_WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  seq_branch_comparator #(.BUS_WIDTH(BW), .SLICE_WIDTH(64)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic z; logic n; logic nu; logic t; logic il;} res_t;

  // Reference: whole-operand comparisons, no slicing.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] f3);
    res_t r;
    r.z  = (a == b);
    r.n  = ($signed(a) < $signed(b));
    r.nu = (a < b);
    r.il = 1'b0;
    r.t  = 1'b0;
    case (f3)
      3'b000:  r.t = r.z;
      3'b001:  r.t = !r.z;
      3'b100:  r.t = r.n;
      3'b101:  r.t = !r.n;
      3'b110:  r.t = r.nu;
      3'b111:  r.t = !r.nu;
      default: r.il = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic res_t obs();
    return {bus.zero, bus.neg, bus.negu, bus.taken, bus.illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation on the 16-bit-slice DUT and leaves the result pending.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                       output int lat, output res_t r, output bit rdy_low);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      step();
      w++;
    end
    bus.in_valid  = 1'b1;
    bus.in1       = a;
    bus.in2       = b;
    bus.funct3    = f3;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.in1      = rnd64();
    bus.in2      = rnd64();
    bus.funct3   = 3'($urandom);
    lat          = 0;
    rdy_low      = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) rdy_low = 1'b0;
      step();
      lat++;
    end
    if (bus.in_ready) rdy_low = 1'b0;
    if (!bus.out_valid) lat = -1;
    r = obs();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || obs() !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b flags=%b want 1 0 00000",
               bus.in_ready, bus.out_valid, obs());
    end
  endtask

  task automatic test_equal();
    int lat; res_t r; bit rl; logic [63:0] v;
    v = 64'h1234_5678_9ABC_DEF0;
    do_op(v, v, 3'b000, lat, r, rl);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL eq_latency: got %0d want 4", lat); end
    total++;
    if (r !== 5'b10010) begin bad++; $display("FAIL eq_flags: got %b want 10010", r); end
    total++;
    if (!rl) begin bad++; $display("FAIL eq_in_ready: got high while busy want low"); end
    drain();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL eq_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid,
               bus.in_ready);
    end
  endtask

  task automatic test_signed();
    int lat; res_t r; bit rl;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, lat, r, rl);
    total++;
    if (r !== 5'b01010) begin bad++; $display("FAIL blt_neg1: got %b want 01010", r); end
    drain();
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b110, lat, r, rl);
    total++;
    if (r !== 5'b01000) begin bad++; $display("FAIL bltu_neg1: got %b want 01000", r); end
    drain();
  endtask

  task automatic test_lsb_slice();
    int lat; res_t r; bit rl;
    do_op(64'hAAAA_BBBB_CCCC_0005, 64'hAAAA_BBBB_CCCC_0007, 3'b111, lat, r, rl);
    total++;
    if (r !== 5'b01100) begin bad++; $display("FAIL lsb_slice: got %b want 01100", r); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat; res_t r; res_t exp; bit rl; logic [63:0] a, b; logic [2:0] f3;
    a   = rnd64();
    b   = {a[63:32], rnd64() >> 32};
    f3  = 3'b101;
    exp = model(a, b, f3);
    do_op(a, b, f3, lat, r, rl);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || obs() !== exp) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b rdy=%b flags=%b want 1 0 %b", i, bus.out_valid,
                 bus.in_ready, obs(), exp);
      end
    end
    drain();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid,
               bus.in_ready);
    end
  endtask

  task automatic test_flush();
    int lat; int seen; res_t r; bit rl; logic [63:0] a, b;
    bus.in_valid = 1'b1;
    bus.in1      = 64'd3;
    bus.in2      = 64'd3;
    bus.funct3   = 3'b000;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_busy: in_ready=%b out_valid=%b want 1 0", bus.in_ready,
               bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL flush_no_pulse: got %0d want 0", seen); end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_idle_accept: in_ready=%b want 1", bus.in_ready);
    end
    do_op(rnd64(), rnd64(), 3'b000, lat, r, rl);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_done: out_valid=%b in_ready=%b want 0 1", bus.out_valid,
               bus.in_ready);
    end
    a = rnd64();
    b = a ^ 64'h0000_0000_0001_0000;
    do_op(a, b, 3'b001, lat, r, rl);
    total++;
    if (r !== model(a, b, 3'b001) || lat !== 4) begin
      bad++;
      $display("FAIL after_flush: got %b lat %0d want %b lat 4", r, lat, model(a, b, 3'b001));
    end
    drain();
  endtask

  task automatic test_illegal();
    int lat; res_t r; bit rl; logic [2:0] f3;
    for (int i = 0; i < 4; i++) begin
      f3 = (i % 2 == 0) ? 3'b010 : 3'b011;
      do_op(rnd64(), rnd64(), f3, lat, r, rl);
      total++;
      if (r.il !== 1'b1 || r.t !== 1'b0) begin
        bad++;
        $display("FAIL illegal_f3_%0d: il=%b t=%b want 1 0", f3, r.il, r.t);
      end
      drain();
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat; res_t r; bit rl;
    do_op(64'd9, 64'd9, 3'b000, lat, r, rl);
    drain();
    bus.in_valid = 1'b1;
    bus.in1      = 64'd9;
    bus.in2      = 64'd9;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || obs() !== 5'b0) begin
      bad++;
      $display("FAIL reset_mid_busy: rdy=%b valid=%b flags=%b want 1 0 00000", bus.in_ready,
               bus.out_valid, obs());
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    int lat; res_t r; res_t exp; bit rl; logic [63:0] a, b, m; logic [2:0] f3;
    int s;
    for (int i = 0; i < 40; i++) begin
      a = rnd64();
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin
          s = $urandom_range(0, 3);
          m = 64'hFFFF << (16 * s);
          b = a ^ (m & rnd64());
        end
        2: b = {~a[63], a[62:0]};
        default: b = rnd64();
      endcase
      f3  = 3'($urandom);
      exp = model(a, b, f3);
      do_op(a, b, f3, lat, r, rl);
      total++;
      if (r !== exp || lat !== 4 || !rl) begin
        bad++;
        $display("FAIL random%0d: a=%h b=%h f3=%b got %b lat %0d want %b lat 4", i, a, b, f3,
                 r, lat, exp);
      end
      drain();
    end
  endtask

  task automatic test_full_slice();
    int lat; res_t r; logic [63:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 64'h1234_5678_9ABC_DEF0 : rnd64();
      b = (i == 0) ? 64'h1234_5678_9ABC_DEF0 : rnd64();
      bus1.in_valid = 1'b1;
      bus1.in1      = a;
      bus1.in2      = b;
      bus1.funct3   = (i == 0) ? 3'b000 : 3'b100;
      step();
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 10) begin
        step();
        lat++;
      end
      r = {bus1.zero, bus1.neg, bus1.negu, bus1.taken, bus1.illegal};
      total++;
      if (lat !== 1 || r !== model(a, b, (i == 0) ? 3'b000 : 3'b100)) begin
        bad++;
        $display("FAIL full_slice%0d: lat %0d flags %b want lat 1 flags %b", i, lat, r,
                 model(a, b, (i == 0) ? 3'b000 : 3'b100));
      end
      bus1.out_ready = 1'b1;
      step();
      bus1.out_ready = 1'b0;
      total++;
      if (bus1.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL full_slice_release%0d: out_valid=%b want 0", i, bus1.out_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.funct3    = '0;
    bus.out_ready = 1'b0;
    bus1.flush    = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in1      = '0;
    bus1.in2      = '0;
    bus1.funct3   = '0;
    bus1.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    test_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    test_equal();
    test_signed();
    test_lsb_slice();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid_busy();
    test_random();
    test_full_slice();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
